// File: rtl/int_ctrl_gen_pkg.sv
// int_ctrl_pkg: shared constants and helpers for the int_ctrl_gen controller.
// Holds default parameter values, lvl/edge mode encoding and counter-width helper.
package int_ctrl_pkg;

    // Default build parameters
    localparam int N_CH_DEF     = 13;
    localparam int SYNC_STG_DEF = 2;
    localparam int DEB_CYC_DEF  = 4;
    localparam int CNT_W_DEF    = 8;

    // lvl_mode bit encoding
    localparam logic MODE_EDGE = 1'b0;
    localparam logic MODE_LVL  = 1'b1;

    // Bits needed to hold values 0..cyc (clog2(cyc+1)), never below 1
    function automatic int deb_cnt_w(input int cyc);
        int w;
        w = 1;
        while ((1 << w) < (cyc + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/int_deb_ch.sv
// int_deb_ch: one channel's input synchroniser, debouncer and one-cycle delay.
// Ports: clk, res (sync, active-high), i_raw (async pin), o_deb, o_deb_q.
module int_deb_ch
    import int_ctrl_pkg::*;
#(
    parameter int SYNC_STG = SYNC_STG_DEF,
    parameter int DEB_CYC  = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic res,
    input  logic i_raw,
    output logic o_deb,
    output logic o_deb_q
);

    logic [SYNC_STG-1:0] r_sync;
    logic                w_sync;
    logic                w_deb;
    logic                r_deb_q;

    always_ff @(posedge clk) begin
        if (res) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], i_raw};
        end
    end

    assign w_sync = r_sync[SYNC_STG-1];

    generate
        if (DEB_CYC == 0) begin : g_no_deb
            assign w_deb = w_sync;
        end else begin : g_deb
            localparam int CW = deb_cnt_w(DEB_CYC);

            logic [CW-1:0] r_cnt;
            logic          r_deb;

            // Counter runs only while sync disagrees with the accepted level;
            // any agreement (a glitch ending) restarts the count from zero.
            always_ff @(posedge clk) begin
                if (res) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (w_sync == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(DEB_CYC - 1)) begin
                    r_deb <= w_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_deb = r_deb;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (res) begin
            r_deb_q <= 1'b0;
        end else begin
            r_deb_q <= w_deb;
        end
    end

    assign o_deb   = w_deb;
    assign o_deb_q = r_deb_q;

endmodule

// File: rtl/int_ctrl_gen.sv
// int_ctrl_gen: N_CH-channel interrupt controller with edge/level detection,
// sticky status, enable/clear and a registered interrupt line.
// Ports: clk, res (sync, active-high), in_raw, int_ena, int_clr, edge_pos,
//        edge_neg, lvl_mode (all N_CH), int_sts, in_deb (N_CH), interrupt,
//        evt_cnt (N_CH*CNT_W, only when INT_CTRL_GEN_CNT_EN is defined).
// Optional macro INT_CTRL_GEN_CNT_EN adds saturating per-channel event counters.
module int_ctrl_gen
    import int_ctrl_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int SYNC_STG = SYNC_STG_DEF,
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [N_CH-1:0]       in_raw,
    input  logic [N_CH-1:0]       int_ena,
    input  logic [N_CH-1:0]       int_clr,
    input  logic [N_CH-1:0]       edge_pos,
    input  logic [N_CH-1:0]       edge_neg,
    input  logic [N_CH-1:0]       lvl_mode,
    output logic [N_CH-1:0]       int_sts,
    output logic [N_CH-1:0]       in_deb,
`ifdef INT_CTRL_GEN_CNT_EN
    output logic [N_CH*CNT_W-1:0] evt_cnt,
`endif
    output logic                  interrupt
);

    generate
        if (N_CH < 1 || N_CH > 32 || SYNC_STG < 2 ||
            DEB_CYC < 0 || CNT_W < 1) begin : g_bad_param
            $error("int_ctrl_gen: parameter out of range");
        end
    endgenerate

    logic [N_CH-1:0] w_deb;
    logic [N_CH-1:0] w_deb_q;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;
    logic [N_CH-1:0] w_evt;
    logic [N_CH-1:0] w_sts_nxt;
    logic [N_CH-1:0] r_sts;
    logic            r_irq;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            int_deb_ch #(
                .SYNC_STG (SYNC_STG),
                .DEB_CYC  (DEB_CYC)
            ) u_deb (
                .clk     (clk),
                .res     (res),
                .i_raw   (in_raw[g]),
                .o_deb   (w_deb[g]),
                .o_deb_q (w_deb_q[g])
            );
        end
    endgenerate

    // Edge tracking ignores int_ena so a freshly enabled channel
    // never sees an edge that happened while it was disabled.
    assign w_rise = w_deb & ~w_deb_q;
    assign w_fall = ~w_deb & w_deb_q;
    assign w_evt  = (w_rise & edge_pos) | (w_fall & edge_neg);

    // Edge mode: set beats clear so a coincident event is never lost.
    always_comb begin
        w_sts_nxt = r_sts;
        for (int i = 0; i < N_CH; i++) begin
            if (lvl_mode[i] == MODE_LVL) begin
                w_sts_nxt[i] = int_ena[i] & w_deb[i];
            end else if (!int_ena[i]) begin
                w_sts_nxt[i] = 1'b0;
            end else if (w_evt[i]) begin
                w_sts_nxt[i] = 1'b1;
            end else if (int_clr[i]) begin
                w_sts_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_sts <= '0;
            r_irq <= 1'b0;
        end else begin
            r_sts <= w_sts_nxt;
            r_irq <= |r_sts;
        end
    end

    assign int_sts   = r_sts;
    assign in_deb    = w_deb;
    assign interrupt = r_irq;

`ifdef INT_CTRL_GEN_CNT_EN
    logic [N_CH-1:0][CNT_W-1:0] r_cnt;
    logic [N_CH-1:0]            w_cnt_inc;

    assign w_cnt_inc = w_evt & int_ena & ~lvl_mode;

    // Clear and increment in the same cycle leave exactly one event counted.
    always_ff @(posedge clk) begin
        if (res) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (int_clr[i]) begin
                    r_cnt[i] <= w_cnt_inc[i] ? CNT_W'(1) : '0;
                end else if (w_cnt_inc[i] && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign evt_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_int_ctrl_gen.sv
// Scoreboard bench for int_ctrl_gen with default timing (SYNC_STG=2, DEB_CYC=4).
// Driver queues expected values; a negedge monitor pops and compares them.
module tb_int_ctrl_gen;

    localparam int N  = 13;
    localparam int CW = 2;

    localparam int K_STS    = 0;
    localparam int K_DEB    = 1;
    localparam int K_IRQ    = 2;
    localparam int K_ALL    = 3;
    localparam int K_DEBALL = 4;
    localparam int K_CNT    = 5;

    logic         clk = 1'b0;
    logic         res;
    logic [N-1:0] in_raw;
    logic [N-1:0] int_ena;
    logic [N-1:0] int_clr;
    logic [N-1:0] edge_pos;
    logic [N-1:0] edge_neg;
    logic [N-1:0] lvl_mode;
    logic [N-1:0] int_sts;
    logic [N-1:0] in_deb;
    logic         interrupt;
`ifdef INT_CTRL_GEN_CNT_EN
    logic [N*CW-1:0] evt_cnt;
`endif

    always #5 clk = ~clk;

    int_ctrl_gen #(
        .N_CH     (N),
        .SYNC_STG (2),
        .DEB_CYC  (4),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .res       (res),
        .in_raw    (in_raw),
        .int_ena   (int_ena),
        .int_clr   (int_clr),
        .edge_pos  (edge_pos),
        .edge_neg  (edge_neg),
        .lvl_mode  (lvl_mode),
        .int_sts   (int_sts),
        .in_deb    (in_deb),
`ifdef INT_CTRL_GEN_CNT_EN
        .evt_cnt   (evt_cnt),
`endif
        .interrupt (interrupt)
    );

    typedef struct {
        int          cyc;
        int          kind;
        int          ch;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          mi;
    logic [31:0] got;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_val(input int kind, input int ch);
        logic [31:0] v;
        v = '0;
        case (kind)
            K_STS:    v[0] = int_sts[ch];
            K_DEB:    v[0] = in_deb[ch];
            K_IRQ:    v[0] = interrupt;
            K_ALL:    v[N-1:0] = int_sts;
            K_DEBALL: v[N-1:0] = in_deb;
`ifdef INT_CTRL_GEN_CNT_EN
            K_CNT:    v[CW-1:0] = evt_cnt[ch*CW +: CW];
`endif
            default:  v = 32'hdead_beef;
        endcase
        return v;
    endfunction

    task automatic expect_at(input int off, input int kind, input int ch,
                             input logic [31:0] e, input string nm);
        exp_t x;
        x.cyc  = cyc + off;
        x.kind = kind;
        x.ch   = ch;
        x.exp  = e;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        mi = 0;
        while (mi < sb.size()) begin
            if (sb[mi].cyc <= cyc) begin
                got = get_val(sb[mi].kind, sb[mi].ch);
                checks++;
                if (sb[mi].cyc < cyc || got !== sb[mi].exp) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                             sb[mi].name, cyc, got, sb[mi].exp);
                end
                sb.delete(mi);
            end else begin
                mi++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        res      = 1'b1;
        in_raw   = '0;
        int_ena  = '0;
        int_clr  = '0;
        edge_pos = '0;
        edge_neg = '0;
        lvl_mode = '0;
        tick(1);
        checks++;
        if (int_sts !== '0) begin
            failures++;
            $display("FAIL d_rst_sts got=%0h", int_sts);
        end
        checks++;
        if (in_deb !== '0) begin
            failures++;
            $display("FAIL d_rst_deb got=%0h", in_deb);
        end
        checks++;
        if (interrupt !== 1'b0) begin
            failures++;
            $display("FAIL d_rst_irq got=%0b", interrupt);
        end
        expect_at(1, K_ALL, 0, 32'h0, "rst_sts");
        expect_at(1, K_DEBALL, 0, 32'h0, "rst_deb");
        expect_at(1, K_IRQ, 0, 32'h0, "rst_irq");
        tick(2);
        res = 1'b0;
        tick(2);

        int_ena[0]  = 1'b1;
        edge_pos[0] = 1'b1;
        tick(1);
        in_raw[0] = 1'b1;
        expect_at(5, K_DEB, 0, 32'h0, "t1_deb_pre");
        expect_at(6, K_DEB, 0, 32'h1, "t1_deb");
        expect_at(6, K_STS, 0, 32'h0, "t1_sts_pre");
        expect_at(7, K_STS, 0, 32'h1, "t1_sts");
        expect_at(7, K_IRQ, 0, 32'h0, "t1_irq_pre");
        expect_at(8, K_IRQ, 0, 32'h1, "t1_irq");
        tick(10);
        checks++;
        if (int_sts[0] !== 1'b1) begin
            failures++;
            $display("FAIL d_t1_sts got=%0b", int_sts[0]);
        end
        checks++;
        if (interrupt !== 1'b1) begin
            failures++;
            $display("FAIL d_t1_irq got=%0b", interrupt);
        end
        int_clr[0] = 1'b1;
        expect_at(1, K_STS, 0, 32'h0, "t1_clr_sts");
        expect_at(1, K_IRQ, 0, 32'h1, "t1_clr_irq_hold");
        expect_at(2, K_IRQ, 0, 32'h0, "t1_clr_irq");
        tick(1);
        int_clr[0] = 1'b0;
        tick(3);

        int_ena[2]  = 1'b1;
        edge_pos[2] = 1'b1;
        tick(1);
        in_raw[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            expect_at(k, K_DEB, 2, 32'h0, "t2_glitch_deb");
        end
        expect_at(8, K_STS, 2, 32'h0, "t2_glitch_sts");
        expect_at(12, K_IRQ, 0, 32'h0, "t2_glitch_irq");
        tick(3);
        in_raw[2] = 1'b0;
        tick(12);
        in_raw[2] = 1'b1;
        expect_at(5, K_DEB, 2, 32'h0, "t2_pulse_deb_pre");
        expect_at(6, K_DEB, 2, 32'h1, "t2_pulse_deb");
        expect_at(7, K_STS, 2, 32'h1, "t2_pulse_sts");
        expect_at(8, K_IRQ, 0, 32'h1, "t2_pulse_irq");
        tick(4);
        in_raw[2] = 1'b0;
        tick(10);
        int_clr[2] = 1'b1;
        expect_at(1, K_STS, 2, 32'h0, "t2_clr_sts");
        expect_at(2, K_IRQ, 0, 32'h0, "t2_clr_irq");
        tick(1);
        int_clr[2] = 1'b0;
        tick(2);

        int_ena[1]  = 1'b1;
        edge_pos[1] = 1'b1;
        tick(1);
        in_raw[1] = 1'b1;
        tick(6);
        int_clr[1] = 1'b1;
        expect_at(1, K_STS, 1, 32'h1, "t3_set_wins");
        tick(1);
        int_clr[1] = 1'b0;
        expect_at(1, K_STS, 1, 32'h1, "t3_hold");
        expect_at(1, K_IRQ, 0, 32'h1, "t3_irq");
        tick(4);
        int_clr[1] = 1'b1;
        expect_at(1, K_STS, 1, 32'h0, "t3_clr_sts");
        expect_at(1, K_IRQ, 0, 32'h1, "t3_clr_irq_hold");
        expect_at(2, K_IRQ, 0, 32'h0, "t3_clr_irq");
        tick(1);
        int_clr[1] = 1'b0;
        tick(3);

        lvl_mode[3] = 1'b1;
        int_ena[3]  = 1'b1;
        tick(1);
        in_raw[3] = 1'b1;
        expect_at(6, K_STS, 3, 32'h0, "t4_sts_pre");
        expect_at(7, K_STS, 3, 32'h1, "t4_sts");
        tick(8);
        int_clr[3] = 1'b1;
        expect_at(1, K_STS, 3, 32'h1, "t4_clr_ign1");
        tick(1);
        int_clr[3] = 1'b0;
        tick(1);
        int_clr[3] = 1'b1;
        expect_at(1, K_STS, 3, 32'h1, "t4_clr_ign2");
        tick(1);
        int_clr[3] = 1'b0;
        tick(2);
        in_raw[3] = 1'b0;
        expect_at(5, K_DEB, 3, 32'h1, "t4_deb_hi");
        expect_at(6, K_DEB, 3, 32'h0, "t4_deb_lo");
        expect_at(6, K_STS, 3, 32'h1, "t4_sts_hold");
        expect_at(7, K_STS, 3, 32'h0, "t4_sts_lo");
        expect_at(7, K_IRQ, 0, 32'h1, "t4_irq_hold");
        expect_at(8, K_IRQ, 0, 32'h0, "t4_irq_lo");
        tick(10);

        edge_pos[4] = 1'b1;
        tick(1);
        in_raw[4] = 1'b1;
        expect_at(7, K_STS, 4, 32'h0, "t5_dis_sts");
        expect_at(10, K_STS, 4, 32'h0, "t5_dis_sts2");
        tick(10);
        int_ena[4] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            expect_at(k, K_STS, 4, 32'h0, "t5_ena_stale");
        end
        tick(4);
        in_raw[4] = 1'b0;
        tick(8);
        in_raw[4] = 1'b1;
        expect_at(6, K_STS, 4, 32'h0, "t5_new_pre");
        expect_at(7, K_STS, 4, 32'h1, "t5_new");
        tick(9);

        int_ena[5]  = 1'b1;
        edge_neg[5] = 1'b1;
        tick(1);
        in_raw[5] = 1'b1;
        expect_at(7, K_STS, 5, 32'h0, "t5_neg_rise");
        tick(9);
        in_raw[5] = 1'b0;
        expect_at(6, K_STS, 5, 32'h0, "t5_neg_pre");
        expect_at(7, K_STS, 5, 32'h1, "t5_neg_fall");
        tick(9);

        int_ena[6]  = 1'b1;
        edge_pos[6] = 1'b1;
        tick(1);
        in_raw[6] = 1'b1;
        tick(3);
        res = 1'b1;
        expect_at(1, K_ALL, 0, 32'h0, "t6_rst_sts");
        expect_at(1, K_DEBALL, 0, 32'h0, "t6_rst_deb");
        expect_at(1, K_IRQ, 0, 32'h0, "t6_rst_irq");
        tick(2);
        res = 1'b0;
        expect_at(5, K_DEB, 6, 32'h0, "t6_deb_pre");
        expect_at(6, K_DEB, 6, 32'h1, "t6_deb");
        expect_at(6, K_ALL, 0, 32'h0, "t6_sts_pre");
        expect_at(7, K_ALL, 0, 32'h53, "t6_sts_reacq");
        expect_at(8, K_IRQ, 0, 32'h1, "t6_irq");
        tick(10);
        int_clr = '1;
        expect_at(1, K_ALL, 0, 32'h0, "t6_clr_all");
        expect_at(2, K_IRQ, 0, 32'h0, "t6_clr_irq");
        tick(1);
        int_clr = '0;
        tick(3);

`ifdef INT_CTRL_GEN_CNT_EN
        int_ena[7]  = 1'b1;
        edge_pos[7] = 1'b1;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            in_raw[7] = 1'b1;
            tick(8);
            in_raw[7] = 1'b0;
            tick(8);
            if (k == 1) expect_at(1, K_CNT, 7, 32'h2, "cnt_two");
        end
        expect_at(1, K_CNT, 7, 32'h3, "cnt_sat");
        int_clr[7] = 1'b1;
        expect_at(1, K_CNT, 7, 32'h0, "cnt_clr");
        tick(1);
        int_clr[7] = 1'b0;
        tick(1);
        in_raw[7] = 1'b1;
        tick(6);
        int_clr[7] = 1'b1;
        expect_at(1, K_CNT, 7, 32'h1, "cnt_clr_evt");
        tick(1);
        int_clr[7] = 1'b0;
        tick(3);
`endif

        tick(3);
        while (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s never sampled exp=%0h", sb[0].name, sb[0].exp);
            void'(sb.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
